// File: rtl/liang_pkg.sv
// Shared pipeline payload types and FIFO defaults for the liang core.
// Payload structs size DATA_W of the inter-stage buffers.
package liang_pkg;

   localparam int PIPE_FIFO_DEPTH_DEFAULT = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
      logic        fault;
   } ifToId_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
   } uop_info_t;

   // Index width for n entries; a single entry still needs one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_wrap_ctr.sv
// Wrapping 0..MAX-1 counter with synchronous clear.
// Used as the read and write pointers of pipe_stage_fifo.
module pipe_wrap_ctr
   import liang_pkg::*;
#(
   parameter  int MAX = 2,
   localparam int W   = ptr_w(MAX)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] val_o
);

   logic at_max;

   // Explicit compare so non power-of-two sizes wrap correctly.
   assign at_max = (val_o == W'(MAX - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         val_o <= '0;
      end else if (clr_i) begin
         val_o <= '0;
      end else if (inc_i) begin
         val_o <= at_max ? '0 : val_o + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready buffer between pipeline stages, registered output.
// Define PIPE_STAGE_FIFO_READY_BYPASS_EN to accept a push into a full buffer that pops.
module pipe_stage_fifo
   import liang_pkg::*;
#(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = PIPE_FIFO_DEPTH_DEFAULT,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CW-1:0]     count_o
);

   localparam int PW = ptr_w(DEPTH);

   if (DEPTH < 1) begin : g_bad_depth
      $error("pipe_stage_fifo: DEPTH must be >= 1");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

`ifdef PIPE_STAGE_FIFO_READY_BYPASS_EN
   // Full but draining: head leaves while the new entry lands.
   assign in_ready_o = !full || out_ready_i;
`else
   assign in_ready_o = !full;
`endif

   assign out_valid_o = !empty;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign count_o     = count;
   assign out_data_o  = empty ? '0 : mem[rd_ptr];

   pipe_wrap_ctr #(
      .MAX (DEPTH)
   ) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (push),
      .val_o  (wr_ptr)
   );

   pipe_wrap_ctr #(
      .MAX (DEPTH)
   ) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (pop),
      .val_o  (rd_ptr)
   );

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem[wr_ptr] <= in_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (flush_i) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_in_stable: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !in_ready_o) |=> (!in_valid_i || $stable(in_data_i))
   );

   a_count_max: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      count <= CW'(DEPTH)
   );
`endif

endmodule
